bank_htu_req_sequencer: RTL and testbench
=========================================

// Module: bank_htu_req_sequencer
// PURPOSE
//  Per-bank request sequencer in front of bank_htu_set_entry.
//  - Accepts one read/write/flush/invalidate request at a time and drives the op/tag/offset lookup inputs.
//  - On a miss, writes back the dirty offsets of the PLRU victim, then refills the requested offset from sub memory.
//  - Pulses set_hit_WV to commit the tag/state/PLRU update, then returns a response.
// PARAMETERS
//  OFFSET_BIT  5  address bit selecting offset0/offset1 of a cacheline
//  SET_LSB     6  lowest set-index address bit; set index = addr[9:SET_LSB]
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   asynchronous active-low reset
//  req_valid_i       in   1   request valid
//  req_ready_o       out  1   request accepted when valid&ready
//  req_op_i          in   2   0 read, 1 write, 2 flush, 3 invalidate
//  req_addr_i        in   32  request byte address
//  op_is_read_o      out  1   to set entry; likewise _write_o, _flush_o, _invalidate_o (4 ports, 1b each)
//  access_tag_o      out  22  latched addr[31:10]
//  access_offset_o   out  1   latched addr[OFFSET_BIT]
//  set_hit_WV_o      out  1   one-cycle commit pulse to set entry / PLRU
//  cacheline_hit_i   in   1   from set entry
//  need_evit_i       in   1   victim has a dirty offset
//  evit_tag_i        in   22  victim tag
//  off0_state_i      in   2   accessed/victim way offset0 state (2'b10 = dirty)
//  off1_state_i      in   2   offset1 state
//  access_way_i      in   3   hit or victim way
//  mem_req_valid_o   out  1   sub-memory request
//  mem_req_ready_i   in   1   sub-memory accept
//  mem_req_write_o   out  1   1 writeback, 0 refill read
//  mem_req_addr_o    out  32  {tag, addr[9:SET_LSB], offset, zeros}
//  mem_req_way_o     out  3   way whose data array is read/written
//  mem_resp_valid_i  in   1   refill data returned
//  resp_valid_o      out  1   response valid, held until resp_ready_i
//  resp_ready_i      in   1   response accept
//  resp_hit_o        out  1   lookup hit
//  resp_way_o        out  3   way used
// BEHAVIOUR
//  - States: IDLE, LOOKUP, EVICT, REFILL, COMMIT, RESP.
//  - Reset (rst_i=0, any state, async): FSM->IDLE; all registered outputs 0.
//    - In-flight mem request dropped; a late mem_resp_valid_i is ignored in IDLE.
//    - req_ready_o=1 only in IDLE.
//  - IDLE: on req_valid_i&req_ready_o, latch op/addr; ->LOOKUP next cycle.
//  - op_is_* driven from the latched op in LOOKUP..COMMIT; all 0 in IDLE/RESP.
//  - LOOKUP (exactly 1 cycle): latch hit, way, evit_tag, and dirty mask {off1==2'b10, off0==2'b10}.
//    - read/write hit, invalidate hit: ->COMMIT.
//    - flush hit: accessed offset dirty -> EVICT with mask = that offset only; else ->COMMIT.
//    - read miss: need_evit_i -> EVICT (victim mask); else -> REFILL.
//    - write miss: need_evit_i -> EVICT, then COMMIT (no refill; full-offset write).
//    - flush/invalidate miss: ->RESP with resp_hit_o=0, no commit.
//  - EVICT: one mem write per set mask bit, offset0 first.
//    - Writeback tag: latched evit_tag (miss) or access tag (flush).
//    - mem_req_valid_o held stable until mem_req_ready_i; each beat clears its mask bit.
//    - Mask empty -> REFILL for read miss, else ->COMMIT.
//  - REFILL: mem read of the requested offset, address uses access tag.
//    - Hold valid until ready, then wait for mem_resp_valid_i (any number of cycles).
//    - mem_resp_valid_i in the same cycle as the accept counts; then ->COMMIT.
//  - COMMIT: set_hit_WV_o=1 for exactly one cycle; ->RESP.
//  - RESP: resp_valid_o=1 with resp_hit_o/resp_way_o stable until resp_ready_i; ->IDLE.
//    - No new request is accepted in that cycle.
//  - Timing:
//    - Minimum latency, accept to resp_valid_o: 3 cycles (LOOKUP, COMMIT, RESP).
//    - Back-to-back requests: one idle cycle apart.
//  - Victim stability: no commit occurs before COMMIT, so the PLRU victim and set state do not change during EVICT/REFILL.
// TESTING
//  1. Read addr 0x0000_1400 into empty set -> REFILL read of 0x1400.
//     - mem_resp after 4 cycles -> one set_hit_WV pulse -> resp_hit=0, resp_way=victim.
//     - Repeat read -> resp_hit=1, 3-cycle latency, no mem traffic.
//  2. Fill 8 ways, dirty both offsets of the PLRU victim (tag 0x2A), read new tag.
//     - Mem writes for offset0 then offset1 at tag 0x2A, then refill read.
//     - mem_req_ready held low 3 cycles: addr/valid stay stable throughout.
//  3. Flush hit with offset1 dirty, offset0 clean -> exactly one mem write (offset1), commit, resp_hit=1.
//     - Flush miss -> resp_hit=0, no set_hit_WV.
//  4. Write miss, victim clean -> no mem traffic, commit, resp_hit=0.
//  5. rst_i low during REFILL wait -> IDLE, outputs 0.
//     - Stale mem_resp_valid ignored; next read completes normally.
//  6. resp_ready_i low 5 cycles with req_valid_i high -> resp held, req_ready_o=0, no second accept.

Source files
------------

// File: rtl/bank_htu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bank_htu_req_sequencer
// Brief    : Per-bank request sequencer driving bank_htu_set_entry lookups,
//            victim writeback, refill and the commit/response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bank_htu_req_sequencer #(
    parameter int OFFSET_BIT = 5,
    parameter int SET_LSB    = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    output logic        op_is_read_o,
    output logic        op_is_write_o,
    output logic        op_is_flush_o,
    output logic        op_is_invalidate_o,
    output logic [21:0] access_tag_o,
    output logic        access_offset_o,
    output logic        set_hit_WV_o,
    input  logic        cacheline_hit_i,
    input  logic        need_evit_i,
    input  logic [21:0] evit_tag_i,
    input  logic [1:0]  off0_state_i,
    input  logic [1:0]  off1_state_i,
    input  logic [2:0]  access_way_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_req_write_o,
    output logic [31:0] mem_req_addr_o,
    output logic [2:0]  mem_req_way_o,
    input  logic        mem_resp_valid_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_hit_o,
    output logic [2:0]  resp_way_o
);

    localparam logic [1:0] c_OP_READ  = 2'd0;
    localparam logic [1:0] c_OP_WRITE = 2'd1;
    localparam logic [1:0] c_OP_FLUSH = 2'd2;
    localparam logic [1:0] c_OP_INV   = 2'd3;
    localparam logic [1:0] c_DIRTY    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EVICT  = 3'd2,
        S_REFILL = 3'd3,
        S_COMMIT = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_addr;
    logic        r_hit;
    logic [2:0]  r_way;
    logic [21:0] r_evit_tag;
    logic [1:0]  r_mask;
    logic        r_refill_sent;

    logic [1:0]  w_dirty;
    logic [1:0]  w_mask_next;
    logic        w_active;
    logic        w_read_miss;
    state_t      w_after_evict;
    logic [21:0] w_mem_tag;
    logic        w_mem_off;
    logic [31:0] w_mem_addr;
    logic        w_unused_addr;

    assign w_dirty       = {off1_state_i == c_DIRTY, off0_state_i == c_DIRTY};
    // Offset0 is written back first, so the lowest set mask bit is the current beat.
    assign w_mask_next   = r_mask[0] ? {r_mask[1], 1'b0} : 2'b00;
    assign w_read_miss   = (r_op == c_OP_READ) && !r_hit;
    assign w_after_evict = w_read_miss ? S_REFILL : S_COMMIT;
    assign w_active      = (r_state == S_LOOKUP) || (r_state == S_EVICT) ||
                           (r_state == S_REFILL) || (r_state == S_COMMIT);
    assign w_unused_addr = ^r_addr;

    always_comb begin
        w_mem_tag  = r_addr[31:10];
        w_mem_off  = r_addr[OFFSET_BIT];
        // Miss writebacks target the victim line; flush writebacks the accessed line.
        if (r_state == S_EVICT) begin
            w_mem_off = ~r_mask[0];
            if (r_op != c_OP_FLUSH) begin
                w_mem_tag = r_evit_tag;
            end
        end
        w_mem_addr                 = '0;
        w_mem_addr[31:10]          = w_mem_tag;
        w_mem_addr[9:SET_LSB]      = r_addr[9:SET_LSB];
        w_mem_addr[OFFSET_BIT]     = w_mem_off;
    end

    assign req_ready_o        = (r_state == S_IDLE);
    assign op_is_read_o       = w_active && (r_op == c_OP_READ);
    assign op_is_write_o      = w_active && (r_op == c_OP_WRITE);
    assign op_is_flush_o      = w_active && (r_op == c_OP_FLUSH);
    assign op_is_invalidate_o = w_active && (r_op == c_OP_INV);
    assign access_tag_o       = r_addr[31:10];
    assign access_offset_o    = r_addr[OFFSET_BIT];
    assign set_hit_WV_o       = (r_state == S_COMMIT);
    assign mem_req_valid_o    = ((r_state == S_EVICT) && (r_mask != 2'b00)) ||
                                ((r_state == S_REFILL) && !r_refill_sent);
    assign mem_req_write_o    = (r_state == S_EVICT);
    assign mem_req_addr_o     = w_mem_addr;
    assign mem_req_way_o      = r_way;
    assign resp_valid_o       = (r_state == S_RESP);
    assign resp_hit_o         = r_hit;
    assign resp_way_o         = r_way;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_op          <= c_OP_READ;
            r_addr        <= '0;
            r_hit         <= 1'b0;
            r_way         <= '0;
            r_evit_tag    <= '0;
            r_mask        <= '0;
            r_refill_sent <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_op    <= req_op_i;
                        r_addr  <= req_addr_i;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_hit         <= cacheline_hit_i;
                    r_way         <= access_way_i;
                    r_evit_tag    <= evit_tag_i;
                    r_refill_sent <= 1'b0;
                    r_mask        <= w_dirty;
                    case (r_op)
                        c_OP_READ: begin
                            if (cacheline_hit_i)  r_state <= S_COMMIT;
                            else if (need_evit_i) r_state <= S_EVICT;
                            else                  r_state <= S_REFILL;
                        end
                        c_OP_WRITE: begin
                            if (!cacheline_hit_i && need_evit_i) r_state <= S_EVICT;
                            else                                 r_state <= S_COMMIT;
                        end
                        c_OP_FLUSH: begin
                            if (!cacheline_hit_i) begin
                                r_state <= S_RESP;
                            end else if (w_dirty[r_addr[OFFSET_BIT]]) begin
                                r_mask  <= r_addr[OFFSET_BIT] ? 2'b10 : 2'b01;
                                r_state <= S_EVICT;
                            end else begin
                                r_state <= S_COMMIT;
                            end
                        end
                        default: begin
                            r_state <= cacheline_hit_i ? S_COMMIT : S_RESP;
                        end
                    endcase
                end
                S_EVICT: begin
                    if (r_mask == 2'b00) begin
                        r_state <= w_after_evict;
                    end else if (mem_req_ready_i) begin
                        r_mask <= w_mask_next;
                        if (w_mask_next == 2'b00) begin
                            r_state <= w_after_evict;
                        end
                    end
                end
                S_REFILL: begin
                    if (!r_refill_sent) begin
                        if (mem_req_ready_i) begin
                            r_refill_sent <= 1'b1;
                            if (mem_resp_valid_i) r_state <= S_COMMIT;
                        end
                    end else if (mem_resp_valid_i) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_htu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_htu_req_sequencer
// Brief    : Directed scoreboard bench for bank_htu_req_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_htu_req_sequencer;

    localparam logic [1:0] c_RD = 2'd0;
    localparam logic [1:0] c_WR = 2'd1;
    localparam logic [1:0] c_FL = 2'd2;
    localparam logic [1:0] c_IV = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic        op_is_read_o, op_is_write_o, op_is_flush_o, op_is_invalidate_o;
    logic [21:0] access_tag_o;
    logic        access_offset_o;
    logic        set_hit_WV_o;
    logic        cacheline_hit_i;
    logic        need_evit_i;
    logic [21:0] evit_tag_i;
    logic [1:0]  off0_state_i, off1_state_i;
    logic [2:0]  access_way_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_req_write_o;
    logic [31:0] mem_req_addr_o;
    logic [2:0]  mem_req_way_o;
    logic        mem_resp_valid_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic        resp_hit_o;
    logic [2:0]  resp_way_o;

    always #5 clk_i = ~clk_i;

    bank_htu_req_sequencer #(.OFFSET_BIT(5), .SET_LSB(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i),
        .op_is_read_o(op_is_read_o), .op_is_write_o(op_is_write_o),
        .op_is_flush_o(op_is_flush_o), .op_is_invalidate_o(op_is_invalidate_o),
        .access_tag_o(access_tag_o), .access_offset_o(access_offset_o),
        .set_hit_WV_o(set_hit_WV_o),
        .cacheline_hit_i(cacheline_hit_i), .need_evit_i(need_evit_i),
        .evit_tag_i(evit_tag_i), .off0_state_i(off0_state_i),
        .off1_state_i(off1_state_i), .access_way_i(access_way_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_write_o(mem_req_write_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_way_o(mem_req_way_o), .mem_resp_valid_i(mem_resp_valid_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o)
    );

    int total = 0;
    int bad   = 0;
    logic [35:0] mem_q[$];
    logic [3:0]  resp_q[$];
    int mem_cnt = 0, resp_cnt = 0, sh_cnt = 0, acc_cnt = 0;
    bit hs_flag = 0, hs_write = 0, pend = 0, same_cycle = 0, st_flag = 0;
    int pend_n = 0, wait_n = 0, stall = 0, resp_lat = 0;
    logic [35:0] st_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: handshakes pop expectations, pulses are counted.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (st_flag) begin
                check("stall_valid_held", mem_req_valid_o, 1);
                check("stall_req_stable", {mem_req_write_o, mem_req_addr_o, mem_req_way_o}, st_val);
            end
            st_flag = mem_req_valid_o && !mem_req_ready_i;
            st_val  = {mem_req_write_o, mem_req_addr_o, mem_req_way_o};
            if (mem_req_valid_o && mem_req_ready_i) begin
                mem_cnt++;
                hs_flag  = 1;
                hs_write = mem_req_write_o;
                if (mem_q.size() == 0) check("mem_unexpected", mem_q.size(), 1);
                else check("mem_req", {mem_req_write_o, mem_req_addr_o, mem_req_way_o}, mem_q.pop_front());
            end
            if (resp_valid_o && resp_ready_i) begin
                resp_cnt++;
                if (resp_q.size() == 0) check("resp_unexpected", resp_q.size(), 1);
                else check("resp", {resp_hit_o, resp_way_o}, resp_q.pop_front());
            end
            if (set_hit_WV_o) sh_cnt++;
            if (req_valid_i && req_ready_o) acc_cnt++;
        end
    end

    // Sub-memory responder with configurable accept stall and read latency.
    always @(posedge clk_i) begin
        #1;
        mem_resp_valid_i = 1'b0;
        if (hs_flag) begin
            hs_flag = 0;
            mem_req_ready_i = 1'b0;
            wait_n = 0;
            if (!hs_write && !same_cycle) begin
                pend = 1;
                pend_n = resp_lat;
            end
        end
        if (pend) begin
            if (pend_n == 0) begin
                mem_resp_valid_i = 1'b1;
                pend = 0;
            end else begin
                pend_n--;
            end
        end
        if (mem_req_valid_o && !mem_req_ready_i) begin
            if (wait_n >= stall) begin
                mem_req_ready_i = 1'b1;
                if (same_cycle && !mem_req_write_o) mem_resp_valid_i = 1'b1;
            end else begin
                wait_n++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                         input logic ev, input logic [21:0] etag, input logic [1:0] s0,
                         input logic [1:0] s1, input logic [2:0] way);
        int n;
        cacheline_hit_i = hit;
        need_evit_i     = ev;
        evit_tag_i      = etag;
        off0_state_i    = s0;
        off1_state_i    = s1;
        access_way_i    = way;
        req_op_i        = op;
        req_addr_i      = addr;
        req_valid_i     = 1'b1;
        n = 0;
        while (!req_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_timeout", n, 0);
        tick();
        req_valid_i = 1'b0;
        check("op_decode", {op_is_invalidate_o, op_is_flush_o, op_is_write_o, op_is_read_o}, 4'b0001 << op);
        check("access_tag", access_tag_o, addr[31:10]);
        check("access_offset", access_offset_o, addr[5]);
    endtask

    task automatic complete(input int exp_commit, input int exp_lat, input string nm);
        int sh0, r0, lat;
        sh0 = sh_cnt;
        lat = 1;
        while (!resp_valid_o && lat < 300) begin
            tick();
            lat++;
        end
        check({nm, "_resp_seen"}, resp_valid_o, 1);
        if (exp_lat > 0) check({nm, "_latency"}, lat, exp_lat);
        r0 = resp_cnt;
        tick();
        check({nm, "_commits"}, sh_cnt - sh0, exp_commit);
        check({nm, "_resp_count"}, resp_cnt, r0 + 1);
        check({nm, "_idle_ready"}, req_ready_o, 1);
    endtask

    function automatic logic [31:0] maddr(input logic [21:0] tag, input logic [3:0] set, input logic off);
        return {tag, set, off, 5'b0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, a0, r0, sh0, n;
        bit busy;
        rst_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0;
        cacheline_hit_i = 1'b0; need_evit_i = 1'b0; evit_tag_i = '0;
        off0_state_i = '0; off1_state_i = '0; access_way_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; resp_ready_i = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {op_is_read_o, op_is_write_o, op_is_flush_o, op_is_invalidate_o,
              set_hit_WV_o, mem_req_valid_o, mem_req_write_o, resp_valid_o, resp_hit_o,
              resp_way_o, access_tag_o, access_offset_o, mem_req_addr_o, mem_req_way_o}, 0);
        rst_i = 1'b1;
        tick();
        check("idle_ready", req_ready_o, 1);

        // Read miss into empty set, then the same read hits.
        resp_lat = 3;
        mem_q.push_back({1'b0, 32'h0000_1400, 3'd3});
        resp_q.push_back({1'b0, 3'd3});
        issue(c_RD, 32'h0000_1400, 0, 0, 22'h0, 2'b00, 2'b00, 3'd3);
        complete(1, 0, "t1_miss");
        m0 = mem_cnt;
        resp_q.push_back({1'b1, 3'd3});
        issue(c_RD, 32'h0000_1400, 1, 0, 22'h0, 2'b01, 2'b00, 3'd3);
        complete(1, 3, "t1_hit");
        check("t1_hit_no_mem", mem_cnt, m0);

        // Dirty victim tag 0x2A: two writebacks then refill, each stalled.
        stall = 3;
        mem_q.push_back({1'b1, maddr(22'h2A, 4'd2, 1'b0), 3'd5});
        mem_q.push_back({1'b1, maddr(22'h2A, 4'd2, 1'b1), 3'd5});
        mem_q.push_back({1'b0, maddr(22'h33, 4'd2, 1'b1), 3'd5});
        resp_q.push_back({1'b0, 3'd5});
        issue(c_RD, maddr(22'h33, 4'd2, 1'b1), 0, 1, 22'h2A, 2'b10, 2'b10, 3'd5);
        complete(1, 0, "t2_evict");
        stall = 0;

        // Flush hit with only offset1 dirty, then a flush miss.
        mem_q.push_back({1'b1, maddr(22'h11, 4'd1, 1'b1), 3'd2});
        resp_q.push_back({1'b1, 3'd2});
        issue(c_FL, maddr(22'h11, 4'd1, 1'b1), 1, 0, 22'h3FF, 2'b01, 2'b10, 3'd2);
        complete(1, 0, "t3_flush_hit");
        m0 = mem_cnt;
        resp_q.push_back({1'b0, 3'd1});
        issue(c_FL, 32'h0000_8000, 0, 1, 22'h15, 2'b10, 2'b10, 3'd1);
        complete(0, 2, "t3_flush_miss");
        check("t3_miss_no_mem", mem_cnt, m0);

        // Write miss with clean victim, then with offset0-only dirty victim.
        m0 = mem_cnt;
        resp_q.push_back({1'b0, 3'd6});
        issue(c_WR, 32'h1234_5678, 0, 0, 22'h1, 2'b01, 2'b01, 3'd6);
        complete(1, 3, "t4_wr_clean");
        check("t4_no_mem", mem_cnt, m0);
        mem_q.push_back({1'b1, maddr(22'h7, 4'd1, 1'b0), 3'd4});
        resp_q.push_back({1'b0, 3'd4});
        issue(c_WR, 32'h0000_0C40, 0, 1, 22'h7, 2'b10, 2'b01, 3'd4);
        complete(1, 0, "t4_wr_dirty");

        resp_q.push_back({1'b1, 3'd7});
        issue(c_IV, 32'h0000_0400, 1, 0, 22'h0, 2'b01, 2'b01, 3'd7);
        complete(1, 3, "inv_hit");

        // Refill data returned in the same cycle as the request accept.
        same_cycle = 1;
        mem_q.push_back({1'b0, 32'h0000_2000, 3'd0});
        resp_q.push_back({1'b0, 3'd0});
        issue(c_RD, 32'h0000_2000, 0, 0, 22'h0, 2'b00, 2'b00, 3'd0);
        complete(1, 0, "same_cycle_resp");
        same_cycle = 0;

        // Reset while waiting for refill data; the late response must be ignored.
        resp_lat = 10;
        m0 = mem_cnt;
        mem_q.push_back({1'b0, 32'h0000_3000, 3'd1});
        resp_q.push_back({1'b0, 3'd1});
        issue(c_RD, 32'h0000_3000, 0, 0, 22'h0, 2'b00, 2'b00, 3'd1);
        n = 0;
        while (mem_cnt == m0 && n < 50) begin
            tick();
            n++;
        end
        check("t5_refill_issued", mem_cnt, m0 + 1);
        tick();
        tick();
        #2 rst_i = 1'b0;
        #1;
        check("t5_reset_outputs", {op_is_read_o, op_is_write_o, op_is_flush_o, op_is_invalidate_o,
              set_hit_WV_o, mem_req_valid_o, mem_req_write_o, resp_valid_o, resp_hit_o,
              resp_way_o, access_tag_o, mem_req_addr_o}, 0);
        check("t5_reset_ready", req_ready_o, 1);
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        resp_q.delete();
        sh0 = sh_cnt;
        busy = 0;
        repeat (14) begin
            tick();
            if (resp_valid_o || mem_req_valid_o || set_hit_WV_o || !req_ready_o) busy = 1;
        end
        check("t5_stale_ignored", busy, 0);
        check("t5_no_commit", sh_cnt - sh0, 0);
        resp_q.push_back({1'b1, 3'd1});
        issue(c_RD, 32'h0000_3000, 1, 0, 22'h0, 2'b01, 2'b00, 3'd1);
        complete(1, 3, "t5_after_reset");

        // Response back-pressure with a second request already waiting.
        resp_ready_i = 1'b0;
        resp_q.push_back({1'b1, 3'd3});
        issue(c_RD, 32'h0000_1400, 1, 0, 22'h0, 2'b01, 2'b00, 3'd3);
        req_valid_i = 1'b1;
        n = 0;
        while (!resp_valid_o && n < 50) begin
            tick();
            n++;
        end
        a0 = acc_cnt;
        r0 = resp_cnt;
        repeat (5) begin
            check("t6_ready_low", req_ready_o, 0);
            check("t6_resp_held", {resp_valid_o, resp_hit_o, resp_way_o}, 5'b11011);
            tick();
        end
        check("t6_no_accept", acc_cnt, a0);
        check("t6_no_resp", resp_cnt, r0);
        resp_q.push_back({1'b1, 3'd3});
        resp_ready_i = 1'b1;
        tick();
        check("t6_first_resp", resp_cnt, r0 + 1);
        check("t6_idle_gap", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        check("t6_second_accept", acc_cnt, a0 + 1);
        complete(1, 3, "t6_second");

        check("mem_queue_drained", mem_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
